// File: rtl/aes_pkg.sv
// +--------------------------------------------------------------------------+
// | aes_pkg: AES-128 constants (round count, Rcon, S-box) and word helpers.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package aes_pkg;

  localparam int NR = 10;

  localparam logic [7:0] RCON [NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
// +--------------------------------------------------------------------------+
// | aes_sbox: ten independent 32-bit SubBytes lanes, purely combinational.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module aes_sbox
  import aes_pkg::*;
(
  input  logic [31:0] in_block_0,
  input  logic [31:0] in_block_1,
  input  logic [31:0] in_block_2,
  input  logic [31:0] in_block_3,
  input  logic [31:0] in_block_4,
  input  logic [31:0] in_block_5,
  input  logic [31:0] in_block_6,
  input  logic [31:0] in_block_7,
  input  logic [31:0] in_block_8,
  input  logic [31:0] in_block_9,
  output logic [31:0] out_block_0,
  output logic [31:0] out_block_1,
  output logic [31:0] out_block_2,
  output logic [31:0] out_block_3,
  output logic [31:0] out_block_4,
  output logic [31:0] out_block_5,
  output logic [31:0] out_block_6,
  output logic [31:0] out_block_7,
  output logic [31:0] out_block_8,
  output logic [31:0] out_block_9
);

  logic [31:0] w_in  [10];
  logic [31:0] w_out [10];

  assign w_in[0] = in_block_0;
  assign w_in[1] = in_block_1;
  assign w_in[2] = in_block_2;
  assign w_in[3] = in_block_3;
  assign w_in[4] = in_block_4;
  assign w_in[5] = in_block_5;
  assign w_in[6] = in_block_6;
  assign w_in[7] = in_block_7;
  assign w_in[8] = in_block_8;
  assign w_in[9] = in_block_9;

  genvar g;
  generate
    for (g = 0; g < 10; g++) begin : g_lane
      assign w_out[g] = sub_word(w_in[g]);
    end
  endgenerate

  assign out_block_0 = w_out[0];
  assign out_block_1 = w_out[1];
  assign out_block_2 = w_out[2];
  assign out_block_3 = w_out[3];
  assign out_block_4 = w_out[4];
  assign out_block_5 = w_out[5];
  assign out_block_6 = w_out[6];
  assign out_block_7 = w_out[7];
  assign out_block_8 = w_out[8];
  assign out_block_9 = w_out[9];

endmodule

`default_nettype wire

// File: rtl/aes128_keymap.sv
// +--------------------------------------------------------------------------+
// | aes128_keymap: iterative AES-128 key expansion, one round key per clock. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module aes128_keymap
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  output logic [127:0] round_key_1,
  output logic [127:0] round_key_2,
  output logic [127:0] round_key_3,
  output logic [127:0] round_key_4,
  output logic [127:0] round_key_5,
  output logic [127:0] round_key_6,
  output logic [127:0] round_key_7,
  output logic [127:0] round_key_8,
  output logic [127:0] round_key_9,
  output logic [127:0] round_key_10,
  output logic         ready
);

  logic [127:0] r_prev_key;
  logic [3:0]   r_rnd;
  logic [127:0] r_round_key [NR];
  logic         r_ready;

  logic         w_active;
  logic [7:0]   w_rcon;
  logic [31:0]  w_t;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_next;

  assign w_active = (r_rnd < 4'(NR));
  // Guard the table lookup so the idle state (rnd = 10) never indexes past Rcon.
  assign w_rcon   = w_active ? RCON[r_rnd] : 8'h00;

  assign sboxw  = r_prev_key[31:0];
  assign w_t    = rot_word(new_sboxw) ^ {w_rcon, 24'h000000};
  assign w_n0   = r_prev_key[127:96] ^ w_t;
  assign w_n1   = r_prev_key[95:64]  ^ w_n0;
  assign w_n2   = r_prev_key[63:32]  ^ w_n1;
  assign w_n3   = r_prev_key[31:0]   ^ w_n2;
  assign w_next = {w_n0, w_n1, w_n2, w_n3};

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_prev_key <= key;
      r_rnd      <= 4'd0;
      r_ready    <= 1'b0;
      for (int i = 0; i < NR; i++) begin
        r_round_key[i] <= '0;
      end
    end else if (w_active) begin
      for (int i = 0; i < NR; i++) begin
        if (r_rnd == 4'(i)) begin
          r_round_key[i] <= w_next;
        end
      end
      r_prev_key <= w_next;
      r_rnd      <= r_rnd + 4'd1;
      r_ready    <= (r_rnd == 4'(NR - 1));
    end
  end

  assign round_key_1  = r_round_key[0];
  assign round_key_2  = r_round_key[1];
  assign round_key_3  = r_round_key[2];
  assign round_key_4  = r_round_key[3];
  assign round_key_5  = r_round_key[4];
  assign round_key_6  = r_round_key[5];
  assign round_key_7  = r_round_key[6];
  assign round_key_8  = r_round_key[7];
  assign round_key_9  = r_round_key[8];
  assign round_key_10 = r_round_key[9];
  assign ready        = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_aes128_keymap.sv
// +--------------------------------------------------------------------------+
// | tb_aes128_keymap: directed + random checks of the key schedule against a |
// | GF(2^8)-derived reference model. Revision: 1.0                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_aes128_keymap;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [127:0] key = '0;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [127:0] dut_rk [1:10];
  logic         ready;
  logic [31:0]  lane_in  [1:9];
  logic [31:0]  lane_out [1:9];

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   m_sbox [256];
  logic [127:0] exp_rk [1:10];

  always #5 clk = ~clk;

  aes128_keymap u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key          (key),
    .sboxw        (sboxw),
    .new_sboxw    (new_sboxw),
    .round_key_1  (dut_rk[1]),
    .round_key_2  (dut_rk[2]),
    .round_key_3  (dut_rk[3]),
    .round_key_4  (dut_rk[4]),
    .round_key_5  (dut_rk[5]),
    .round_key_6  (dut_rk[6]),
    .round_key_7  (dut_rk[7]),
    .round_key_8  (dut_rk[8]),
    .round_key_9  (dut_rk[9]),
    .round_key_10 (dut_rk[10]),
    .ready        (ready)
  );

  aes_sbox u_sbox (
    .in_block_0  (sboxw),
    .in_block_1  (lane_in[1]),
    .in_block_2  (lane_in[2]),
    .in_block_3  (lane_in[3]),
    .in_block_4  (lane_in[4]),
    .in_block_5  (lane_in[5]),
    .in_block_6  (lane_in[6]),
    .in_block_7  (lane_in[7]),
    .in_block_8  (lane_in[8]),
    .in_block_9  (lane_in[9]),
    .out_block_0 (new_sboxw),
    .out_block_1 (lane_out[1]),
    .out_block_2 (lane_out[2]),
    .out_block_3 (lane_out[3]),
    .out_block_4 (lane_out[4]),
    .out_block_5 (lane_out[5]),
    .out_block_6 (lane_out[6]),
    .out_block_7 (lane_out[7]),
    .out_block_8 (lane_out[8]),
    .out_block_9 (lane_out[9])
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box from its algebraic definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] m_subword(input logic [31:0] w);
    return {m_sbox[w[31:24]], m_sbox[w[23:16]], m_sbox[w[15:8]], m_sbox[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = m_subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 1; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reset edge E0 with key k, then check the cleared state.
  task automatic start(input logic [127:0] k, input string tag);
    reset_n = 1'b1;
    key     = k;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    key     = rand128();
    model_expand(k);
    chk($sformatf("%s reset ready", tag), 128'(ready), 128'(1'b0));
    chk($sformatf("%s reset sboxw", tag), 128'(sboxw), 128'(k[31:0]));
    for (int r = 1; r <= 10; r++)
      chk($sformatf("%s reset rk%0d", tag, r), dut_rk[r], 128'h0);
  endtask

  // Edge E0+k: round key k appears, later ones still zero, ready only at k=10.
  task automatic step(input int k, input string tag);
    chk($sformatf("%s sboxw before edge %0d", tag, k), 128'(sboxw),
        128'(k == 1 ? 32'h0 : exp_rk[k-1][31:0]) | (k == 1 ? 128'(sboxw) : 128'h0));
    @(posedge clk);
    #1;
    key = rand128();
    chk($sformatf("%s ready edge %0d", tag, k), 128'(ready), 128'(k == 10));
    chk($sformatf("%s rk%0d edge %0d", tag, k, k), dut_rk[k], exp_rk[k]);
    if (k < 10)
      chk($sformatf("%s rk%0d early edge %0d", tag, k + 1, k), dut_rk[k+1], 128'h0);
  endtask

  task automatic run(input logic [127:0] k, input string tag);
    start(k, tag);
    for (int s = 1; s <= 10; s++) step(s, tag);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      key = rand128();
      chk($sformatf("%s hold ready c%0d", tag, c), 128'(ready), 128'(1'b1));
      for (int r = 1; r <= 10; r++)
        chk($sformatf("%s hold rk%0d c%0d", tag, r, c), dut_rk[r], exp_rk[r]);
    end
  endtask

  initial begin
    for (int i = 1; i <= 9; i++) lane_in[i] = 32'h0;
    build_sbox();

    // Datapath S-box lanes against the algebraic model.
    for (int it = 0; it < 8; it++) begin
      for (int i = 1; i <= 9; i++) lane_in[i] = $urandom;
      #1;
      for (int i = 1; i <= 9; i++)
        chk($sformatf("sbox lane%0d it%0d", i, it), 128'(lane_out[i]), 128'(m_subword(lane_in[i])));
    end

    // All-zero key with published vectors.
    run(128'h0, "zero");
    chk("zero rk1 vec",  dut_rk[1],  128'h62636363626363636263636362636363);
    chk("zero rk2 vec",  dut_rk[2],  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
    chk("zero rk5 vec",  dut_rk[5],  128'h7f2e2b88f8443e098dda7cbbf34b9290);
    chk("zero rk9 vec",  dut_rk[9],  128'hb1d4d8e28a7db9da1d7bb3de4c664941);
    chk("zero rk10 vec", dut_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Back-to-back: reset straight after completion.
    run(128'h6920e299a5202a6d656e636869746f2a, "b2b");

    // FIPS-197 example key.
    run(128'h2b7e151628aed2a6abf7158809cf4f3c, "fips");
    chk("fips rk1 vec",  dut_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips rk10 vec", dut_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset after round 4 of the FIPS schedule restarts cleanly with key 0.
    start(128'h2b7e151628aed2a6abf7158809cf4f3c, "mid");
    for (int s = 1; s <= 4; s++) step(s, "mid");
    run(128'h0, "mid0");
    chk("mid0 rk1 vec",  dut_rk[1],  128'h62636363626363636263636362636363);
    chk("mid0 rk10 vec", dut_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Random keys, including a multi-cycle reset that re-latches each edge.
    for (int it = 0; it < 3; it++) begin
      reset_n = 1'b1;
      key     = rand128();
      @(posedge clk);
      #1;
      run(rand128(), $sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
